// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int SA_WIDTH_DEF = 8;

endpackage : serial_adder_pkg

// File: rtl/serial_fa_cell.sv
// One-bit combinational full adder: the only arithmetic in the serial datapath.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign s     = w_axb ^ c;
    assign co    = (a & b) | (w_axb & c);

endmodule : serial_fa_cell

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one bit per clock through a single full-adder cell.
// Define SERIAL_ADDER_SUB_EN to make the sub input select a_in - b_in.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_t        r_state;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sub;

    logic w_b;
    logic w_s;
    logic w_co;
    logic w_seed;
    logic w_sub_in;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1: invert B per bit and force the carry seed.
    assign w_sub_in = sub;
    assign w_seed   = sub ? 1'b1 : cin;
    assign w_b      = r_opb[0] ^ r_sub;
`else
    logic w_unused_sub;
    assign w_unused_sub = sub;
    assign w_sub_in     = 1'b0;
    assign w_seed       = cin;
    assign w_b          = r_opb[0] ^ r_sub;
`endif

    serial_fa_cell u_cell (
        .a  (r_opa[0]),
        .b  (w_b),
        .c  (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // Control FSM, operand/result shifting and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_opa    <= '0;
            r_opb    <= '0;
            r_res    <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sub    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_opa   <= a_in;
                        r_opb   <= b_in;
                        r_carry <= w_seed;
                        r_sub   <= w_sub_in;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RUN: begin
                    r_res   <= {w_s, r_res[WIDTH-1:1]};
                    r_carry <= w_co;
                    r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
                    r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
                    // Final bit: r_carry still holds the carry into the MSB.
                    if (r_cnt == LAST_BIT) begin
                        sum      <= {w_s, r_res[WIDTH-1:1]};
                        cout     <= w_co;
                        overflow <= r_carry ^ w_co;
                        done     <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed vectors with hand-computed results.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic prev_done = 1'b0;

    logic [W+1:0] exp_q[$];   // {overflow, cout, sum}
    int           edge_q[$];  // cycle count just after the accepting edge

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin      (cin),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare each done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        logic [W+1:0] e;
        int           ed;
        if (rst_n && done) begin
            chk("done_single_pulse", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e  = exp_q.pop_front();
                ed = edge_q.pop_front();
                chk("sum", {24'd0, sum}, {24'd0, e[W-1:0]});
                chk("cout", {31'd0, cout}, {31'd0, e[W]});
                chk("overflow", {31'd0, overflow}, {31'd0, e[W+1]});
                chk("done_latency", cyc, ed + W);
            end
        end
        prev_done <= done;
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            chk("timeout_idle", 32'd1, 32'd0);
            exp_q.delete();
            edge_q.delete();
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("timeout_done", 32'd1, 32'd0);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic s, input logic [W+1:0] e);
        @(negedge clk);
        a_in = a; b_in = b; cin = c; sub = s; start = 1'b1;
        exp_q.push_back(e);
        edge_q.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        wait_idle();
    endtask

    initial begin
        int e0;
        int last_done;

        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {24'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op(8'h3C, 8'h15, 1'b0, 1'b0, {2'b00, 8'h51});
        op(8'hFF, 8'h01, 1'b1, 1'b0, {2'b01, 8'h01});
        op(8'h7F, 8'h01, 1'b0, 1'b0, {2'b10, 8'h80});
`ifdef SERIAL_ADDER_SUB_EN
        op(8'h05, 8'h07, 1'b1, 1'b1, {2'b00, 8'hFE});
`else
        op(8'h05, 8'h07, 1'b1, 1'b1, {2'b00, 8'h0D});
`endif

        // Second start while busy must be ignored.
        @(negedge clk);
        a_in = 8'h10; b_in = 8'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
        e0 = cyc + 1;
        exp_q.push_back({2'b00, 8'h30});
        edge_q.push_back(e0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a_in = 8'hAA; b_in = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_edge8", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("busy_edge9", {31'd0, busy}, 32'd0);
        wait_idle();
        repeat (12) @(negedge clk);

        // Reset mid-RUN aborts; no result is expected from this start.
        a_in = 8'h21; b_in = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_sum", {24'd0, sum}, 32'd0);
        chk("midrst_cout", {31'd0, cout}, 32'd0);
        chk("midrst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op(8'h01, 8'h01, 1'b0, 1'b0, {2'b00, 8'h02});

        // Start held high: three back-to-back operations.
        @(negedge clk);
        a_in = 8'h11; b_in = 8'h22; cin = 1'b0; start = 1'b1;
        exp_q.push_back({2'b00, 8'h33});
        edge_q.push_back(cyc + 1);
        wait_done();
        last_done = cyc;
        a_in = 8'h80; b_in = 8'h80;
        exp_q.push_back({2'b11, 8'h00});
        edge_q.push_back(cyc + 2);
        @(negedge clk);
        wait_done();
        chk("b2b_spacing1", cyc - last_done, W + 2);
        last_done = cyc;
        a_in = 8'h0F; b_in = 8'h01;
        exp_q.push_back({2'b00, 8'h10});
        edge_q.push_back(cyc + 2);
        @(negedge clk);
        wait_done();
        chk("b2b_spacing2", cyc - last_done, W + 2);
        start = 1'b0;
        @(negedge clk);
        wait_idle();
        repeat (12) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_adder
